// File: rtl/shift_sequencer_if.sv
// Start/busy/done handshake bundle for the multi-cycle shift unit.
// The requester uses the master modport; the shift unit uses the slave modport.
interface shift_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, in_data, shamt, dir,
        input  busy, done, result
    );

    modport slave (
        input  start, in_data, shamt, dir,
        output busy, done, result
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter: applies the 2^idx stages (largest first), one per clock.
// Optional build macro SHIFT_LEFT_EN adds dir-selected left shifting; default is right-only.
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);
    localparam int IDX_W   = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam int N_SLOTS = 1 << IDX_W;
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_shamt;
    logic               w_accept;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic [WIDTH-1:0]   w_stage [N_SLOTS];

`ifdef SHIFT_LEFT_EN
    logic               r_dir;
`endif

    // One candidate per stage; index slots beyond SHAMT_W just hold the value.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_stage
            if (gi < SHAMT_W) begin : g_real
                localparam int SH = 1 << gi;
`ifdef SHIFT_LEFT_EN
                assign w_stage[gi] = r_dir ? (r_work << SH) : (r_work >> SH);
`else
                assign w_stage[gi] = r_work >> SH;
`endif
            end else begin : g_pad
                assign w_stage[gi] = r_work;
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_last       = (r_idx == '0);
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                // A start seen in the done cycle is taken immediately.
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= '0;
            r_shamt <= '0;
            r_idx   <= IDX_FIRST;
`ifdef SHIFT_LEFT_EN
            r_dir   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_work  <= bus.in_data;
            r_shamt <= bus.shamt;
            r_idx   <= IDX_FIRST;
`ifdef SHIFT_LEFT_EN
            r_dir   <= bus.dir;
`endif
        end else if (r_state == SHIFT) begin
            if (r_shamt[r_idx]) begin
                r_work <= w_stage[r_idx];
            end
            r_idx <= w_last ? IDX_FIRST : (r_idx - 1'b1);
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_work;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; each scenario task does its own checks.
// Expected values are hand-computed; the dir test expectation depends on SHIFT_LEFT_EN.
module tb_shift_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation for one edge, then scramble the inputs to prove they were latched.
    task automatic launch(input logic [31:0] d, input logic [4:0] s, input logic dr);
        bus.in_data = d;
        bus.shamt   = s;
        bus.dir     = dr;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.in_data = ~d;
        bus.shamt   = ~s;
        bus.dir     = ~dr;
    endtask

    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.in_data = '0;
        bus.shamt   = '0;
        bus.dir     = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
        $display("reset: busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
    endtask

    task automatic test_basic();
        int cyc, bcnt;
        launch(32'hDEADBEEF, 5'd8, 1'b0);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start: got %b expected 1", bus.busy); end
        wait_done(cyc, bcnt);
        n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d edges expected 5", cyc); end
        n_cmp++; if (bcnt !== 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 5", bcnt); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.result !== 32'h00DEADBE) begin n_fail++; $display("FAIL basic_result: got %h expected 00DEADBE", bus.result); end
        $display("op DEADBEEF>>8: result=%h latency=%0d", bus.result, cyc);
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
        n_cmp++; if (bus.result !== 32'h00DEADBE) begin n_fail++; $display("FAIL basic_result_hold: got %h expected 00DEADBE", bus.result); end
    endtask

    task automatic test_boundary();
        int cyc, bcnt;
        launch(32'h80000000, 5'd31, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++; if (bus.result !== 32'h00000001) begin n_fail++; $display("FAIL shamt31_result: got %h expected 00000001", bus.result); end
        $display("op 80000000>>31: result=%h latency=%0d", bus.result, cyc);
        tick();
        launch(32'hFFFFFFFF, 5'd31, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++; if (bus.result !== 32'h00000001) begin n_fail++; $display("FAIL ones31_result: got %h expected 00000001", bus.result); end
        $display("op FFFFFFFF>>31: result=%h latency=%0d", bus.result, cyc);
        tick();
        launch(32'h12345678, 5'd0, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL shamt0_latency: got %0d edges expected 5", cyc); end
        n_cmp++; if (bus.result !== 32'h12345678) begin n_fail++; $display("FAIL shamt0_result: got %h expected 12345678", bus.result); end
        $display("op 12345678>>0: result=%h latency=%0d", bus.result, cyc);
        tick();
        launch(32'hA5A5A5A5, 5'd5, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++; if (bus.result !== 32'h052D2D2D) begin n_fail++; $display("FAIL shamt5_result: got %h expected 052D2D2D", bus.result); end
        $display("op A5A5A5A5>>5: result=%h latency=%0d", bus.result, cyc);
        tick();
    endtask

    task automatic test_ignore_busy();
        int n_done;
        logic [31:0] res;
        n_done = 0;
        res    = '0;
        launch(32'hDEADBEEF, 5'd4, 1'b0);
        tick();
        bus.in_data = 32'hFFFFFFFF;
        bus.shamt   = 5'd1;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) begin
                n_done++;
                res = bus.result;
            end
            tick();
        end
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d expected 1", n_done); end
        n_cmp++; if (res !== 32'h0DEADBEE) begin n_fail++; $display("FAIL busy_start_result: got %h expected 0DEADBEE", res); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b expected 0", bus.busy); end
        $display("op DEADBEEF>>4 with start while busy: result=%h dones=%0d", res, n_done);
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        launch(32'h0000FFFF, 5'd8, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++; if (bus.result !== 32'h000000FF) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 000000FF", bus.result); end
        $display("op 0000FFFF>>8: result=%h latency=%0d", bus.result, cyc);
        launch(32'hF0000000, 5'd4, 1'b0);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy); end
        wait_done(cyc, bcnt);
        n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL b2b_latency: got %0d edges expected 5", cyc); end
        n_cmp++; if (bus.result !== 32'h0F000000) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 0F000000", bus.result); end
        $display("op F0000000>>4 back-to-back: result=%h latency=%0d", bus.result, cyc);
        tick();
    endtask

    task automatic test_reset_abort();
        int n_done, cyc, bcnt;
        n_done = 0;
        launch(32'hDEADBEEF, 5'd8, 1'b0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h expected 00000000", bus.result); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) n_done++;
            tick();
        end
        n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses expected 0", n_done); end
        $display("abort: busy=%b result=%h stray_dones=%0d", bus.busy, bus.result, n_done);
        launch(32'h0F0F0F0F, 5'd2, 1'b0);
        wait_done(cyc, bcnt);
        n_cmp++; if (bus.result !== 32'h03C3C3C3) begin n_fail++; $display("FAIL abort_recover_result: got %h expected 03C3C3C3", bus.result); end
        $display("op 0F0F0F0F>>2 after abort: result=%h latency=%0d", bus.result, cyc);
        tick();
    endtask

    task automatic test_dir();
        int cyc, bcnt;
        logic [31:0] exp_val;
`ifdef SHIFT_LEFT_EN
        exp_val = 32'h00000010;
`else
        exp_val = 32'h00000000;
`endif
        launch(32'h00000001, 5'd4, 1'b1);
        wait_done(cyc, bcnt);
        n_cmp++; if (bus.result !== exp_val) begin n_fail++; $display("FAIL dir_result: got %h expected %h", bus.result, exp_val); end
        $display("op 00000001 dir=1 shamt=4: result=%h latency=%0d", bus.result, cyc);
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_dir();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
